// File: rtl/edge_period_timer.sv
// Measures clock cycles between consecutive rising-edge strobes and presents
// each period through a one-entry valid/ready register, with loss-of-signal flag.
module edge_period_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 edge_i,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid,
  input  logic                 period_ready,
  output logic                 timeout,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TIMEOUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 capture;
  logic                 transfer;

  assign transfer = period_valid && period_ready;
  assign timeout  = (state == TIMEOUT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // An edge always wins over saturation, so a period of exactly MAX is captured.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (edge_i) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = '0;
          end
        end
        MEASURE: begin
          if (edge_i) begin
            capture = 1'b1;
            cnt_nxt = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            state_nxt = TIMEOUT;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        TIMEOUT: begin
          if (edge_i) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_o     <= '0;
      period_valid <= 1'b0;
    end else if (capture) begin
      period_o     <= cnt;
      period_valid <= 1'b1;
    end else if (transfer) begin
      period_valid <= 1'b0;
    end
  end

  // Overrun only when an unconsumed value is lost, not when it leaves the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun <= 1'b0;
    end else if (!enable) begin
      overrun <= 1'b0;
    end else if (capture && period_valid && !period_ready) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_edge_period_timer.sv
// Randomized scoreboard bench for edge_period_timer; the reference model works
// from edge timestamps rather than counter/state emulation.
module tb_edge_period_timer;

  localparam int CNT_WIDTH = 5;
  localparam int MAX = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic                 edge_i;
  logic                 enable;
  logic [CNT_WIDTH-1:0] period_o;
  logic                 period_valid;
  logic                 period_ready;
  logic                 timeout;
  logic                 overrun;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int cyc = 0;
  int t_last = 0;
  bit armed = 1'b0;
  bit mdl_valid = 1'b0;
  bit exp_overrun = 1'b0;
  bit exp_timeout = 1'b0;

  edge_period_timer #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .edge_i       (edge_i),
    .enable       (enable),
    .period_o     (period_o),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .timeout      (timeout),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: a period is the timestamp difference of two edges while armed,
  // valid only if the gap does not exceed MAX; longer gaps only re-arm.
  task automatic modelStep(input bit en, input bit e, input bit rdy);
    bit transfer;
    bit cap;
    int val;
    transfer = mdl_valid && rdy;
    cap = 1'b0;
    val = 0;
    if (!en) begin
      armed = 1'b0;
      exp_overrun = 1'b0;
    end else if (e) begin
      if (armed && (cyc - t_last) <= MAX) begin
        cap = 1'b1;
        val = cyc - t_last;
      end
      armed = 1'b1;
      t_last = cyc;
    end
    if (cap) begin
      if (mdl_valid && !transfer) begin
        exp_overrun = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      exp_q.push_back(val);
      mdl_valid = 1'b1;
    end else if (transfer) begin
      mdl_valid = 1'b0;
    end
    exp_timeout = armed && ((cyc - t_last) >= MAX);
  endtask

  task automatic applyStimulus(input bit en, input bit e, input bit rdy);
    enable = en;
    edge_i = e;
    period_ready = rdy;
    @(posedge clk);
    #1;
    modelStep(en, e, rdy);
    cyc++;
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, rdy);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_period"}, int'(period_o), 0);
    checkOutput({tag, "_valid"}, int'(period_valid), 0);
    checkOutput({tag, "_timeout"}, int'(timeout), 0);
    checkOutput({tag, "_overrun"}, int'(overrun), 0);
  endtask

  // Monitor: compares the presented output against the scoreboard head and
  // retires it when the handshake will complete on the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1) begin
        checkOutput("timeout", int'(timeout), int'(exp_timeout));
        checkOutput("overrun", int'(overrun), int'(exp_overrun));
        checkOutput("valid", int'(period_valid), (exp_q.size() > 0) ? 1 : 0);
        if (period_valid && exp_q.size() > 0) begin
          checkOutput("period", int'(period_o), exp_q[0]);
          if (period_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int edge_pct;
    int rdy_pct;
    n_rst = 1'b0;
    enable = 1'b0;
    edge_i = 1'b0;
    period_ready = 1'b0;
    #12;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Basic periods 5 and 10.
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, (i == 10 || i == 15 || i == 25), 1'b1);
    // Back-to-back edges.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, (i >= 4 && i <= 6), 1'b1);

    // Exact MAX gap, then timeout, re-arm, and a 7-cycle period.
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(MAX - 1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(MAX + 6, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(6, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(MAX + 1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);

    // Backpressure, overwrite, single-cycle drain, then enable pulse.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(7, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(11, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    idleCycles(3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Same-cycle capture and transfer.
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(7, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(2, 1'b1);

    // Randomized traffic in varying density and backpressure regimes.
    for (int blk = 0; blk < 24; blk++) begin
      case ($urandom_range(2, 0))
        0: edge_pct = 50;
        1: edge_pct = 10;
        default: edge_pct = 3;
      endcase
      case ($urandom_range(2, 0))
        0: rdy_pct = 100;
        1: rdy_pct = 50;
        default: rdy_pct = 10;
      endcase
      for (int i = 0; i < 100; i++) begin
        applyStimulus(($urandom_range(99, 0) >= 1),
                      ($urandom_range(99, 0) < edge_pct),
                      ($urandom_range(99, 0) < rdy_pct));
      end
    end

    // Asynchronous reset in the middle of an interval.
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(4, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(3, 1'b1);
    #2;
    n_rst = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    mdl_valid = 1'b0;
    exp_overrun = 1'b0;
    exp_timeout = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(posedge clk);
    #3;
    n_rst = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, (i == 3 || i == 9), 1'b1);

    // Drain whatever is left and confirm nothing was lost.
    idleCycles(4, 1'b1);
    checkOutput("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_period_timer.md
Name: edge_period_timer

Overview:
- Measures the interval, in clock cycles, between consecutive single-cycle rising-edge pulses from the upstream rise_edge_detect stage.
- Each completed measurement is presented downstream through a one-entry valid/ready output register.
- A level flag reports loss of signal when no edge arrives before the counter saturates.
- Used to time external pulse trains, e.g. RC/PWM input periods, before downstream decode logic.

Parameters:
CNT_WIDTH, 16, width of the interval counter and of period_o; maximum measurable period is MAX = 2^CNT_WIDTH - 1 cycles.

Ports:
clk  input  1  system clock; all logic on rising edge.
n_rst  input  1  asynchronous active-low reset.
edge_i  input  1  single-cycle rising-edge strobe from rise_edge_detect (rising_edge_found).
enable  input  1  measurement enable; low forces IDLE.
period_o  output  CNT_WIDTH  last captured period in clock cycles.
period_valid  output  1  period_o holds an unconsumed measurement.
period_ready  input  1  downstream accepts period_o this cycle.
timeout  output  1  level; high while in TIMEOUT state.
overrun  output  1  sticky; a capture overwrote an unconsumed measurement.

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE, counter 0, period_o 0, period_valid 0, timeout 0, overrun 0.
- States: IDLE, MEASURE, TIMEOUT. Transitions are evaluated at every clk rising edge.
- enable low, any state: next state IDLE, counter 0, timeout 0, overrun 0. period_o and period_valid are kept and the handshake still completes.
- IDLE: edge_i high with enable high -> MEASURE, counter := 1. Other cycles: stay in IDLE, counter 0. The first edge never produces a measurement.
- MEASURE, counter semantics: counter increments by 1 each cycle without an edge.
- MEASURE, edge_i high: capture. period_o := counter, period_valid := 1, counter := 1, stay in MEASURE.
- Period definition: edges sampled at cycles t0 and t1 give period_o = t1 - t0. Back-to-back edges give 1.
- Capture latency: period_valid rises on the clock edge after the edge_i cycle; period_o is updated on that same edge.
- MEASURE, counter == MAX and edge_i low: -> TIMEOUT, timeout := 1, no capture, counter holds MAX.
- MEASURE, counter == MAX and edge_i high: normal capture of MAX. The edge has priority over timeout.
- Counter never wraps.
- TIMEOUT, edge_i high: -> MEASURE, counter := 1, timeout := 0, no capture. The interval was invalid.
- TIMEOUT, other cycles: stay in TIMEOUT; timeout stays 1.
- Handshake transfer: occurs on any clock edge where period_valid and period_ready are both high.
- Handshake without a same-cycle capture: a transfer clears period_valid.
- period_o stability: stable while period_valid is high and not transferred, except on an overrun overwrite.
- Capture while period_valid is high and no transfer this cycle: period_o := new value, period_valid stays 1, overrun := 1.
- overrun is sticky; cleared only by reset or enable low.
- Capture in the same cycle as a transfer: new value loaded, period_valid stays 1, overrun unchanged.
- period_ready is ignored while period_valid is low.
- Reset asserted mid-measurement: all state is discarded immediately. After release, the first edge only re-arms; it produces no measurement.
- Width: counter and period_o are unsigned CNT_WIDTH.

Test Plan:
- Basic period: enable=1, ready=1; edges at cycles 10, 15, 25 -> period_valid pulses at cycles 16 and 26 with period_o=5 then 10; no valid after cycle 10; timeout=0, overrun=0.
- Back-to-back: edges at cycles 4, 5, 6 -> period_o=1 valid at cycle 6, period_o=1 valid at cycle 7.
- Timeout (CNT_WIDTH=4, MAX=15):
  - Edge at cycle 0, none after -> timeout rises at cycle 16 and holds, no valid.
  - Next edge at cycle 30 -> timeout low at cycle 31, no capture.
  - Edge at cycle 37 -> period_o=7.
  - Separately, edges at cycles 0 and 15 -> period_o=15 with no timeout.
- Backpressure/overrun: ready=0; edges at cycles 0, 8, 20 -> valid at cycle 9 with 8, overwritten at cycle 21 with 12, overrun=1. Then ready=1 for one cycle -> valid drops next cycle; overrun stays 1 until enable is pulsed low.
- Same-cycle capture and transfer: valid high with 8, ready=1 on the cycle an edge yields 6 -> valid stays 1, period_o=6, overrun=0.
- Async reset mid-measure: n_rst low mid-interval between clk edges -> all outputs 0 immediately. After release, edges at cycles 3 and 9 -> only period_o=6 is produced.
